// File: rtl/svc_rv_bpred_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookups are answered one cycle later from pre-update state; resolved branches train entries.
module svc_rv_bpred_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int MODE    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispred,
  input  logic            bp_flush,
  input  logic            stat_clr,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;
  localparam bit DYN = (MODE != 0);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  // Valid bits are the only storage that needs reset; payload arrays stay reset-free.
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];

  logic            r_pred_hit;
  logic            r_pred_taken;
  logic [XLEN-1:0] r_pred_target;
  logic [31:0]     r_stat_lookups;
  logic [31:0]     r_stat_mispred;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_lk_taken;
  logic [XLEN-1:0]  w_lk_target;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_en;
  logic             w_up_match;
  logic             w_up_hit;
  logic             w_up_alloc;
  logic [CTR_W-1:0] w_ctr_cur;
  logic [CTR_W-1:0] w_ctr_next;

  logic             w_unused;

  // Lookup path: reads the arrays before any same-cycle write lands.
  assign w_lk_idx    = pred_pc[IDX_W+1:2];
  assign w_lk_tag    = pred_pc[TAG_HI:TAG_LO];
  assign w_lk_hit    = DYN && !bp_flush && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
  assign w_lk_target = w_lk_taken ? r_target[w_lk_idx] : pred_pc + XLEN'(4);

  assign w_up_idx   = upd_pc[IDX_W+1:2];
  assign w_up_tag   = upd_pc[TAG_HI:TAG_LO];
  assign w_up_en    = DYN && upd_valid && !bp_flush;
  assign w_up_match = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_hit   = w_up_en && w_up_match;
  assign w_up_alloc = w_up_en && !w_up_match && upd_taken;
  assign w_ctr_cur  = r_ctr[w_up_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_W'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (bp_flush) begin
      r_valid <= '0;
    end else if (w_up_alloc) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_up_hit) begin
      r_ctr[w_up_idx] <= w_ctr_next;
      if (upd_taken) r_target[w_up_idx] <= upd_target;
    end else if (w_up_alloc) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
      r_ctr[w_up_idx]    <= CTR_WEAK;
    end
  end

  // An idle cycle clears hit/taken but keeps the last target visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else if (pred_valid) begin
      r_pred_hit    <= w_lk_hit;
      r_pred_taken  <= w_lk_taken;
      r_pred_target <= w_lk_target;
    end else begin
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_lookups <= '0;
      r_stat_mispred <= '0;
    end else if (stat_clr) begin
      r_stat_lookups <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (pred_valid && !(&r_stat_lookups)) r_stat_lookups <= r_stat_lookups + 32'd1;
      if (upd_valid && upd_mispred && !(&r_stat_mispred)) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign pred_hit     = r_pred_hit;
  assign pred_taken   = r_pred_taken;
  assign pred_target  = r_pred_target;
  assign stat_lookups = r_stat_lookups;
  assign stat_mispred = r_stat_mispred;

  assign w_unused = ^{upd_pc[XLEN-1:TAG_HI+1], upd_pc[1:0]};

endmodule

// File: tb/tb_svc_rv_bpred_btb.sv
// Bench for svc_rv_bpred_btb: a dynamic and a static instance share stimulus and are
// compared every cycle against a table-level model, plus directed literal expectations.
module tb_svc_rv_bpred_btb;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int CTR_W   = 2;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int CMAX    = (1 << CTR_W) - 1;
  localparam int WEAK    = 1 << (CTR_W - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispred;
  logic            bp_flush;
  logic            stat_clr;

  logic            m1_hit, m1_taken, m0_hit, m0_taken;
  logic [XLEN-1:0] m1_target, m0_target;
  logic [31:0]     m1_lookups, m1_mispred, m0_lookups, m0_mispred;

  svc_rv_bpred_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_hit(m1_hit), .pred_taken(m1_taken), .pred_target(m1_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .bp_flush(bp_flush), .stat_clr(stat_clr),
    .stat_lookups(m1_lookups), .stat_mispred(m1_mispred)
  );

  svc_rv_bpred_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .MODE(0)) dut_static (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_hit(m0_hit), .pred_taken(m0_taken), .pred_target(m0_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .bp_flush(bp_flush), .stat_clr(stat_clr),
    .stat_lookups(m0_lookups), .stat_mispred(m0_mispred)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          mv  [ENTRIES];
  int          mt  [ENTRIES];
  logic [31:0] mtg [ENTRIES];
  int          mc  [ENTRIES];
  bit          e_hit, e_taken;
  logic [31:0] e_target, e0_target, e_lookups, e_mispred;
  int          li, lt, ui, ut;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
      e_hit = 0; e_taken = 0; e_target = 0; e0_target = 0;
      e_lookups = 0; e_mispred = 0;
    end else begin
      if (pred_valid) begin
        li = idx_of(pred_pc);
        lt = tag_of(pred_pc);
        e_hit     = !bp_flush && mv[li] && (mt[li] == lt);
        e_taken   = e_hit && (mc[li] >= WEAK);
        e_target  = e_taken ? mtg[li] : pred_pc + 32'd4;
        e0_target = pred_pc + 32'd4;
      end else begin
        e_hit = 0;
        e_taken = 0;
      end
      if (bp_flush) begin
        for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
      end else if (upd_valid) begin
        ui = idx_of(upd_pc);
        ut = tag_of(upd_pc);
        if (mv[ui] && mt[ui] == ut) begin
          if (upd_taken) begin
            mc[ui]  = (mc[ui] + 1 > CMAX) ? CMAX : mc[ui] + 1;
            mtg[ui] = upd_target;
          end else begin
            mc[ui] = (mc[ui] - 1 < 0) ? 0 : mc[ui] - 1;
          end
        end else if (upd_taken) begin
          mv[ui] = 1'b1; mt[ui] = ut; mtg[ui] = upd_target; mc[ui] = WEAK;
        end
      end
      if (stat_clr) begin
        e_lookups = 0;
        e_mispred = 0;
      end else begin
        if (pred_valid && e_lookups != 32'hFFFF_FFFF) e_lookups = e_lookups + 1;
        if (upd_valid && upd_mispred && e_mispred != 32'hFFFF_FFFF) e_mispred = e_mispred + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!done) begin
      check("hit",        {31'd0, m1_hit},   {31'd0, e_hit});
      check("taken",      {31'd0, m1_taken}, {31'd0, e_taken});
      check("target",     m1_target,  e_target);
      check("lookups",    m1_lookups, e_lookups);
      check("mispred",    m1_mispred, e_mispred);
      check("s_hit",      {31'd0, m0_hit},   32'd0);
      check("s_taken",    {31'd0, m0_taken}, 32'd0);
      check("s_target",   m0_target,  e0_target);
      check("s_lookups",  m0_lookups, e_lookups);
      check("s_mispred",  m0_mispred, e_mispred);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    pred_valid = 0; pred_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0; upd_mispred = 0;
    bp_flush = 0; stat_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_lookup(input logic [31:0] pc);
    pred_valid = 1; pred_pc = pc;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mis;
  endtask

  task automatic lookup(input logic [31:0] pc);
    set_lookup(pc);
    step();
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    set_update(pc, tk, tgt, 1'b0);
    step();
  endtask

  task automatic expect_out(input string name, input logic h, input logic t, input logic [31:0] tgt);
    check({name, ".hit"},    {31'd0, m1_hit},   {31'd0, h});
    check({name, ".taken"},  {31'd0, m1_taken}, {31'd0, t});
    check({name, ".target"}, m1_target, tgt);
  endtask

  task automatic expect_stats(input string name, input logic [31:0] lk, input logic [31:0] mp);
    check({name, ".lookups"},   m1_lookups, lk);
    check({name, ".mispred"},   m1_mispred, mp);
    check({name, ".s_lookups"}, m0_lookups, lk);
    check({name, ".s_mispred"}, m0_mispred, mp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 32'h0);
    expect_stats("reset", 32'd0, 32'd0);
    rst_n = 1'b1;

    // cold lookup
    lookup(32'h100);
    expect_out("cold", 1'b0, 1'b0, 32'h104);

    // allocate and train
    update(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    expect_out("alloc", 1'b1, 1'b1, 32'h200);
    check("alloc.s_hit", {31'd0, m0_hit}, 32'd0);
    check("alloc.s_target", m0_target, 32'h104);
    update(32'h100, 1'b0, 32'hDEAD_0000);
    update(32'h100, 1'b0, 32'hDEAD_0000);
    lookup(32'h100);
    expect_out("train_nt", 1'b1, 1'b0, 32'h104);
    for (int i = 0; i < 3; i++) update(32'h100, 1'b0, 32'hDEAD_0000);
    update(32'h100, 1'b1, 32'h220);
    lookup(32'h100);
    expect_out("floor", 1'b1, 1'b0, 32'h104);
    for (int i = 0; i < 3; i++) update(32'h100, 1'b1, 32'h220);
    update(32'h100, 1'b0, 32'hDEAD_0000);
    lookup(32'h100);
    expect_out("ceiling", 1'b1, 1'b1, 32'h220);

    // aliasing on index 0
    update(32'h200, 1'b1, 32'h500);
    lookup(32'h100);
    expect_out("alias_old", 1'b0, 1'b0, 32'h104);
    lookup(32'h200);
    expect_out("alias_new", 1'b1, 1'b1, 32'h500);

    // same-cycle lookup and first-time update
    set_lookup(32'h300);
    set_update(32'h300, 1'b1, 32'h340, 1'b0);
    step();
    expect_out("hazard", 1'b0, 1'b0, 32'h304);
    lookup(32'h300);
    expect_out("hazard_next", 1'b1, 1'b1, 32'h340);

    // taken hit rewrites target; low pc bits ignored
    update(32'h300, 1'b1, 32'h380);
    lookup(32'h302);
    expect_out("retarget", 1'b1, 1'b1, 32'h380);

    // not-taken miss leaves the occupant alone
    update(32'h700, 1'b0, 32'h740);
    lookup(32'h700);
    expect_out("nt_miss", 1'b0, 1'b0, 32'h704);
    lookup(32'h300);
    expect_out("nt_keep", 1'b1, 1'b1, 32'h380);

    // idle cycle: hit/taken drop, target holds
    step();
    expect_out("idle", 1'b0, 1'b0, 32'h380);

    // statistics
    stat_clr = 1;
    step();
    expect_stats("clr", 32'd0, 32'd0);
    lookup(32'h100);
    set_lookup(32'h200); set_update(32'h900, 1'b0, 32'h0, 1'b1); step();
    lookup(32'h300);
    set_lookup(32'h400); set_update(32'h904, 1'b0, 32'h0, 1'b1); step();
    lookup(32'h500);
    upd_mispred = 1;
    step();
    expect_stats("stats", 32'd5, 32'd2);

    // flush with concurrent lookup and update
    bp_flush = 1;
    set_lookup(32'h300);
    set_update(32'h600, 1'b1, 32'h640, 1'b0);
    step();
    expect_out("flush", 1'b0, 1'b0, 32'h304);
    lookup(32'h300);
    expect_out("post_flush_a", 1'b0, 1'b0, 32'h304);
    lookup(32'h600);
    expect_out("post_flush_b", 1'b0, 1'b0, 32'h604);
    stat_clr = 1;
    set_lookup(32'h100);
    set_update(32'h900, 1'b0, 32'h0, 1'b1);
    step();
    expect_stats("clr_prio", 32'd0, 32'd0);
    lookup(32'h100);
    expect_stats("after_clr", 32'd1, 32'd0);

    // asynchronous reset mid-update
    update(32'h300, 1'b1, 32'h340);
    lookup(32'h300);
    expect_out("pre_reset", 1'b1, 1'b1, 32'h340);
    set_lookup(32'h300);
    set_update(32'h440, 1'b1, 32'h480, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 32'h0);
    expect_stats("async_reset", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    idle();
    #2;
    rst_n = 1'b1;
    lookup(32'h300);
    expect_out("post_reset_a", 1'b0, 1'b0, 32'h304);
    lookup(32'h440);
    expect_out("post_reset_b", 1'b0, 1'b0, 32'h444);

    // a few random-address lookups exercised only through the model
    for (int i = 0; i < 8; i++) begin
      set_lookup(32'h300 + 32'(i * 4));
      if (i % 2 == 0) set_update(32'h300 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i), 1'b0);
      step();
    end
    repeat (2) step();

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
